// File: rtl/abs_pkg.sv
// -----------------------------------------------------------------------------
// abs_pkg
// Shared types and default constants for the multi-wheel ABS controller.
//   abs_state_t : per-wheel brake-modulation state (IDLE, APPLY, RELEASE, HOLD)
//   DEF_*       : default parameter values used by the top and the channels
//   max_int     : elaboration-time helper that sizes the per-wheel counter
// Configuration macro used elsewhere in the slice: ABS_OBJECT_BRAKE_EN
// -----------------------------------------------------------------------------
package abs_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        APPLY   = 2'd1,
        RELEASE = 2'd2,
        HOLD    = 2'd3
    } abs_state_t;

    localparam int DEF_NUM_WHEELS     = 4;
    localparam int DEF_SPEED_W        = 8;
    localparam int DEF_SLIP_THRESH    = 10;
    localparam int DEF_MIN_SPEED      = 5;
    localparam int DEF_RELEASE_CYCLES = 4;
    localparam int DEF_HOLD_CYCLES    = 6;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/abs_wheel_channel.sv
// -----------------------------------------------------------------------------
// abs_wheel_channel
// One wheel's brake-modulation FSM plus its release/hold down-counter.
// Ports:
//   clk     in   clock, posedge
//   rst     in   asynchronous active-low reset
//   req_q   in   registered brake request (shared by all wheels)
//   slip    in   ref speed minus this wheel's speed, SPEED_W bits unsigned
//   ref_ok  in   reference speed is at or above the minimum for slip control
//   brake   out  brake command (APPLY or HOLD)
//   active  out  ABS intervening on this wheel (RELEASE or HOLD)
// Both outputs decode registered state only.
// -----------------------------------------------------------------------------
module abs_wheel_channel
    import abs_pkg::*;
#(
    parameter int SPEED_W        = DEF_SPEED_W,
    parameter int SLIP_THRESH    = DEF_SLIP_THRESH,
    parameter int RELEASE_CYCLES = DEF_RELEASE_CYCLES,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_q,
    input  logic [SPEED_W-1:0] slip,
    input  logic               ref_ok,
    output logic               brake,
    output logic               active
);

    localparam int CNT_W = $clog2(max_int(RELEASE_CYCLES, HOLD_CYCLES) + 1);

    localparam logic [SPEED_W-1:0] THRESH_V  = SPEED_W'(SLIP_THRESH);
    localparam logic [CNT_W-1:0]   REL_LOAD  = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

    abs_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rel_cond;

    // Strictly greater than the threshold; gated off at low reference speed.
    assign rel_cond = ref_ok && (slip > THRESH_V);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_q) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                if (!req_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (rel_cond) begin
                    state_d = RELEASE;
                    cnt_d   = REL_LOAD;
                end
            end
            RELEASE: begin
                // Request loss wins over counter expiry.
                if (!req_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    if (rel_cond) begin
                        // Slip persists: extend by another full release pulse.
                        cnt_d = REL_LOAD;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            HOLD: begin
                // Slip is deliberately ignored here so the wheel gets braked
                // for the full hold time before it can be released again.
                if (!req_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = APPLY;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign brake  = (state_q == APPLY)   || (state_q == HOLD);
    assign active = (state_q == RELEASE) || (state_q == HOLD);

endmodule

// File: rtl/abs_multi_wheel_controller.sv
// -----------------------------------------------------------------------------
// abs_multi_wheel_controller
// Multi-wheel anti-lock brake controller. Registers wheel speeds and the brake
// request, derives a reference speed as the maximum registered wheel speed,
// and runs one abs_wheel_channel per wheel on its slip against that reference.
// Ports:
//   clk              in   clock, posedge
//   rst              in   asynchronous active-low reset
//   brake_pedal      in   driver brake request
//   Object_detected  in   emergency brake request (used only when
//                         ABS_OBJECT_BRAKE_EN is defined)
//   wheel_speed      in   packed speeds, wheel i at [i*SPEED_W +: SPEED_W]
//   brake_signal     out  per-wheel brake command
//   abs_active       out  per-wheel ABS intervention flag
// Macro: ABS_OBJECT_BRAKE_EN - when defined, Object_detected also requests
// braking; otherwise only brake_pedal does.
// Latency: inputs before edge k affect outputs after edge k+1.
// -----------------------------------------------------------------------------
module abs_multi_wheel_controller
    import abs_pkg::*;
#(
    parameter int NUM_WHEELS     = DEF_NUM_WHEELS,
    parameter int SPEED_W        = DEF_SPEED_W,
    parameter int SLIP_THRESH    = DEF_SLIP_THRESH,
    parameter int MIN_SPEED      = DEF_MIN_SPEED,
    parameter int RELEASE_CYCLES = DEF_RELEASE_CYCLES,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          brake_pedal,
    input  logic                          Object_detected,
    input  logic [NUM_WHEELS*SPEED_W-1:0] wheel_speed,
    output logic [NUM_WHEELS-1:0]         brake_signal,
    output logic [NUM_WHEELS-1:0]         abs_active
);

    localparam logic [SPEED_W-1:0] MIN_V = SPEED_W'(MIN_SPEED);

    logic [NUM_WHEELS*SPEED_W-1:0] spd_q;
    logic [SPEED_W-1:0]            ref_q, ref_d;
    logic                          req_q, req_d;
    logic                          ref_ok;

`ifdef ABS_OBJECT_BRAKE_EN
    assign req_d = brake_pedal | Object_detected;
`else
    logic unused_object_detected;
    assign unused_object_detected = Object_detected;
    assign req_d = brake_pedal;
`endif

    // Linear max chain over the raw inputs; its result is registered together
    // with the speeds so ref_q and spd_q always describe the same sample.
    logic [SPEED_W-1:0] max_chain [NUM_WHEELS+1];
    assign max_chain[0] = '0;

    generate
        for (genvar gi = 0; gi < NUM_WHEELS; gi++) begin : g_max
            assign max_chain[gi+1] =
                (wheel_speed[gi*SPEED_W +: SPEED_W] > max_chain[gi])
                    ? wheel_speed[gi*SPEED_W +: SPEED_W]
                    : max_chain[gi];
        end
    endgenerate

    assign ref_d = max_chain[NUM_WHEELS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spd_q <= '0;
            ref_q <= '0;
            req_q <= 1'b0;
        end else begin
            spd_q <= wheel_speed;
            ref_q <= ref_d;
            req_q <= req_d;
        end
    end

    assign ref_ok = (ref_q >= MIN_V);

    generate
        for (genvar gi = 0; gi < NUM_WHEELS; gi++) begin : g_wheel
            logic [SPEED_W-1:0] slip;
            // ref_q is the max of spd_q, so this never wraps.
            assign slip = ref_q - spd_q[gi*SPEED_W +: SPEED_W];

            abs_wheel_channel #(
                .SPEED_W        (SPEED_W),
                .SLIP_THRESH    (SLIP_THRESH),
                .RELEASE_CYCLES (RELEASE_CYCLES),
                .HOLD_CYCLES    (HOLD_CYCLES)
            ) u_channel (
                .clk    (clk),
                .rst    (rst),
                .req_q  (req_q),
                .slip   (slip),
                .ref_ok (ref_ok),
                .brake  (brake_signal[gi]),
                .active (abs_active[gi])
            );
        end
    endgenerate

endmodule
